pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-sequencing unit for the next-generation datapath: PC register, +1 increment,
//  jump, call/return stack of configurable depth, and vectored interrupt entry/exit.
//  Replaces the fixed 10-bit PC/MUX/stack cluster; its output pc drives the program memory address.
//  Adds stack overflow/underflow detection and interrupt handling, which the fixed cluster lacks.
// PARAMETERS
//  ADDR_W      10     PC / program-address width (bits)
//  STACK_DEPTH 8      return-address stack entries (>=2)
//  N_IRQ       4      interrupt request lines (1..8)
//  IRQ_BASE    10'h3C0 vector of irq[0]; zero-extended/truncated to ADDR_W
//  IRQ_STRIDE  4      address distance between consecutive vectors
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        asynchronous, active-high
//  s_inc       in   1        1: sequential (pc+1); 0: control transfer per s_jal/s_ret/s_reti
//  s_jal       in   1        call: push pc+1, load dir_salto (only when s_inc=0)
//  s_ret       in   1        return: pop into pc (only when s_inc=0)
//  s_reti      in   1        return from interrupt: pop into pc, clear in_isr (only when s_inc=0)
//  dir_salto   in   ADDR_W   jump/call target
//  irq         in   N_IRQ    level-sensitive interrupt requests
//  irq_en      in   1        global interrupt enable
//  clr_err     in   1        synchronous clear of stack_ovf/stack_unf
//  pc          out  ADDR_W   current program address
//  in_isr      out  1        1 while an interrupt service routine runs
//  irq_ack     out  N_IRQ    one-hot, one-cycle pulse on the cycle after acceptance
//  sp_level    out  $clog2(STACK_DEPTH+1)  number of valid stack entries
//  stack_ovf   out  1        sticky: push attempted while full
//  stack_unf   out  1        sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (async): pc=0, sp_level=0, in_isr=0, irq_ack=0, stack_ovf=0, stack_unf=0; stack contents don't-care.
//  All state updates on rising clk; pc changes one cycle after the controlling inputs are sampled.
//  Per-cycle priority (highest first): irq entry > s_reti > s_ret > s_jal > jump > increment.
//   - irq entry: accepted iff irq_en & !in_isr & |irq & s_inc=1. Index k = lowest set irq bit.
//     Push pc+1; pc <= IRQ_BASE + k*IRQ_STRIDE (mod 2^ADDR_W); in_isr <= 1; irq_ack[k] pulses next cycle.
//     Not accepted on control-transfer cycles (s_inc=0); remains pending while irq level holds.
//   - s_inc=1, no irq: pc <= pc+1, wraps 2^ADDR_W-1 -> 0.
//   - s_inc=0 & s_reti: pop -> pc; in_isr <= 0. s_reti with in_isr=0 behaves as s_ret.
//   - s_inc=0 & s_ret (no s_reti): pop -> pc.
//   - s_inc=0 & s_jal (no s_ret/s_reti): push pc+1; pc <= dir_salto.
//   - s_inc=0, no other control bit set: pc <= dir_salto.
//   - s_jal/s_ret/s_reti ignored when s_inc=1.
//  Stack: LIFO, top = entry sp_level-1. Push writes entry sp_level, sp_level+1. Pop reads top, sp_level-1.
//   - Push when full (sp_level=STACK_DEPTH): no write, sp_level unchanged, stack_ovf <= 1; the jump/vector
//     still happens.
//   - Pop when empty: pc <= pc+1, sp_level stays 0, stack_unf <= 1; in_isr still cleared on s_reti.
//  Nested interrupts are not supported: while in_isr=1, irq is ignored; calls inside the ISR use the same stack.
//  clr_err=1 clears both sticky flags; a same-cycle new error takes precedence (flag ends set).
//  Reset asserted mid-ISR or mid-call discards the stack and returns to pc=0 immediately.
// TESTING
//  1 Reset, then 1023 cycles of s_inc=1 (ADDR_W=10) -> pc=1023; next cycle pc=0 (wrap).
//  2 At pc=5: s_inc=0, s_jal=1, dir_salto=0x100 -> pc=0x100, sp_level=1; then s_ret -> pc=6, sp_level=0.
//  3 Nine nested calls (depth 8) -> 9th sets stack_ovf=1, sp_level=8, pc=target; nine returns -> 9th
//    sets stack_unf=1, pc=pc+1; clr_err -> both flags 0.
//  4 irq_en=1, irq=4'b0110 at pc=0x20, s_inc=1 -> pc=0x3C4, in_isr=1, irq_ack=4'b0010 for 1 cycle;
//    s_reti -> pc=0x21, in_isr=0.
//  5 irq held high on a cycle with s_inc=0, s_jal=1 -> call taken, no ack; accepted on next s_inc=1 cycle.
//  6 Assert reset while in_isr=1, sp_level=3 -> pc=0, sp_level=0, in_isr=0, flags 0 without a clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program sequencer: PC register with increment, jump, call/return stack and
// vectored, non-nesting interrupt entry/exit. pc drives the program memory address.
module pc_sequencer #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned N_IRQ       = 4,
    parameter int unsigned IRQ_BASE    = 'h3C0,
    parameter int unsigned IRQ_STRIDE  = 4,
    localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_inc,
    input  logic              s_jal,
    input  logic              s_ret,
    input  logic              s_reti,
    input  logic [ADDR_W-1:0] dir_salto,
    input  logic [N_IRQ-1:0]  irq,
    input  logic              irq_en,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] pc,
    output logic              in_isr,
    output logic [N_IRQ-1:0]  irq_ack,
    output logic [SP_W-1:0]   sp_level,
    output logic              stack_ovf,
    output logic              stack_unf
);

    localparam int unsigned    PTR_W    = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0] FULL_LVL = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] irq_vec;
    logic [ADDR_W-1:0] stack_top;
    logic [N_IRQ-1:0]  irq_onehot;
    logic [31:0]       irq_idx;
    logic              irq_take;
    logic              do_call;
    logic              do_pop;
    logic              do_push;
    logic              full;
    logic              empty;

    // Lowest-numbered active request wins; scan downwards so the last hit is the lowest.
    always_comb begin
        irq_idx    = '0;
        irq_onehot = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) begin
                irq_idx       = 32'(i);
                irq_onehot    = '0;
                irq_onehot[i] = 1'b1;
            end
        end
    end

    assign pc_seq    = pc + ADDR_W'(1);
    assign irq_vec   = ADDR_W'(IRQ_BASE + irq_idx * IRQ_STRIDE);
    assign full      = (sp_level == FULL_LVL);
    assign empty     = (sp_level == '0);
    assign stack_top = stack_mem[PTR_W'(sp_level - SP_W'(1))];

    // Interrupts only enter on sequential cycles, so a pending call/return is never lost.
    assign irq_take = irq_en & ~in_isr & (|irq) & s_inc;
    assign do_pop   = ~s_inc & (s_ret | s_reti);
    assign do_call  = ~s_inc & s_jal & ~s_ret & ~s_reti;
    assign do_push  = irq_take | do_call;

    // Stack contents carry no reset; only sp_level defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !full) begin
            stack_mem[PTR_W'(sp_level)] <= pc_seq;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= '0;
            sp_level  <= '0;
            in_isr    <= 1'b0;
            irq_ack   <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            irq_ack   <= irq_take ? irq_onehot : '0;
            stack_ovf <= (do_push & full) | (stack_ovf & ~clr_err);
            stack_unf <= (do_pop & empty) | (stack_unf & ~clr_err);

            if (do_push && !full) begin
                sp_level <= sp_level + SP_W'(1);
            end else if (do_pop && !empty) begin
                sp_level <= sp_level - SP_W'(1);
            end

            if (irq_take) begin
                pc     <= irq_vec;
                in_isr <= 1'b1;
            end else if (do_pop) begin
                pc <= empty ? pc_seq : stack_top;
                if (s_reti) begin
                    in_isr <= 1'b0;
                end
            end else if (s_inc) begin
                pc <= pc_seq;
            end else begin
                pc <= dir_salto;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for single-cycle behaviour plus
// hand sequences for wrap, stack overflow/underflow and asynchronous reset mid-ISR.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_inc, s_jal, s_ret, s_reti;
    logic [9:0] dir_salto;
    logic [3:0] irq;
    logic       irq_en, clr_err;
    logic [9:0] pc;
    logic       in_isr;
    logic [3:0] irq_ack;
    logic [3:0] sp_level;
    logic       stack_ovf, stack_unf;

    int tests = 0;
    int fails = 0;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .s_inc     (s_inc),
        .s_jal     (s_jal),
        .s_ret     (s_ret),
        .s_reti    (s_reti),
        .dir_salto (dir_salto),
        .irq       (irq),
        .irq_en    (irq_en),
        .clr_err   (clr_err),
        .pc        (pc),
        .in_isr    (in_isr),
        .irq_ack   (irq_ack),
        .sp_level  (sp_level),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s_inc, s_jal, s_ret, s_reti;
        logic [9:0] dir;
        logic [3:0] irq;
        logic       irq_en, clr_err;
        logic [9:0] pc;
        logic [3:0] sp;
        logic       isr;
        logic [3:0] ack;
        logic       ovf, unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic i, logic j, logic r, logic ri, logic [9:0] d,
                                logic [3:0] q, logic en, logic clr, logic [9:0] epc,
                                logic [3:0] esp, logic eisr, logic [3:0] eack,
                                logic eovf, logic eunf);
        vec_t v;
        v.s_inc = i;  v.s_jal = j;  v.s_ret = r;  v.s_reti = ri;
        v.dir = d;    v.irq = q;    v.irq_en = en; v.clr_err = clr;
        v.pc = epc;   v.sp = esp;   v.isr = eisr;  v.ack = eack;
        v.ovf = eovf; v.unf = eunf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic i, input logic j, input logic r, input logic ri,
                         input logic [9:0] d, input logic [3:0] q, input logic en,
                         input logic clr);
        s_inc = i; s_jal = j; s_ret = r; s_reti = ri;
        dir_salto = d; irq = q; irq_en = en; clr_err = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [9:0] mstack[$];
    logic [9:0] mpc;

    initial begin
        reset = 1'b1;
        idle();
        #2;
        check("reset_pc",  32'(pc),        32'h0);
        check("reset_sp",  32'(sp_level),  32'h0);
        check("reset_isr", 32'(in_isr),    32'h0);
        check("reset_ack", 32'(irq_ack),   32'h0);
        check("reset_ovf", 32'(stack_ovf), 32'h0);
        check("reset_unf", 32'(stack_unf), 32'h0);
        tick();
        reset = 1'b0;

        // Sequential run up to the top of the address space, then wrap.
        for (int n = 0; n < 1023; n++) tick();
        check("wrap_top", 32'(pc), 32'd1023);
        tick();
        check("wrap_zero", 32'(pc), 32'd0);

        //            inc  jal  ret  reti dir     irq    en   clr  | pc      sp  isr ack    ovf  unf
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b0000,1'b0,1'b0, 10'h001,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b0000,1'b0,1'b0, 10'h002,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b0000,1'b0,1'b0, 10'h003,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b0000,1'b0,1'b0, 10'h004,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b0000,1'b0,1'b0, 10'h005,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,10'h100,4'b0000,1'b0,1'b0, 10'h100,4'd1,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,10'h2AA,4'b0000,1'b0,1'b0, 10'h101,4'd1,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,10'h2AA,4'b0000,1'b0,1'b0, 10'h006,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,10'h020,4'b0000,1'b0,1'b0, 10'h020,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b0110,1'b1,1'b0, 10'h3C4,4'd1,1'b1,4'b0010,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b0110,1'b1,1'b0, 10'h3C5,4'd1,1'b1,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b0110,1'b1,1'b0, 10'h3C6,4'd1,1'b1,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,10'h000,4'b0000,1'b1,1'b0, 10'h021,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b1000,1'b0,1'b0, 10'h022,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,10'h050,4'b1000,1'b1,1'b0, 10'h050,4'd1,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b1000,1'b1,1'b0, 10'h3CC,4'd2,1'b1,4'b1000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b0000,1'b1,1'b0, 10'h3CD,4'd2,1'b1,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,10'h000,4'b0000,1'b1,1'b0, 10'h051,4'd1,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,10'h000,4'b0000,1'b0,1'b0, 10'h023,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,10'h000,4'b0000,1'b0,1'b0, 10'h024,4'd0,1'b0,4'b0000,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,10'h000,4'b0000,1'b0,1'b0, 10'h025,4'd0,1'b0,4'b0000,1'b0,1'b1));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b0000,1'b0,1'b1, 10'h026,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,10'h000,4'b0000,1'b0,1'b1, 10'h027,4'd0,1'b0,4'b0000,1'b0,1'b1));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,10'h000,4'b0000,1'b0,1'b1, 10'h028,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,10'h200,4'b0000,1'b0,1'b0, 10'h200,4'd1,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,10'h300,4'b0000,1'b0,1'b0, 10'h029,4'd0,1'b0,4'b0000,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,10'h000,4'b0001,1'b1,1'b0, 10'h3C0,4'd1,1'b1,4'b0001,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,10'h000,4'b0000,1'b1,1'b0, 10'h02A,4'd0,1'b0,4'b0000,1'b0,1'b0));

        foreach (vecs[i]) begin
            drive(vecs[i].s_inc, vecs[i].s_jal, vecs[i].s_ret, vecs[i].s_reti,
                  vecs[i].dir, vecs[i].irq, vecs[i].irq_en, vecs[i].clr_err);
            tick();
            check($sformatf("v%0d_pc", i),  32'(pc),        32'(vecs[i].pc));
            check($sformatf("v%0d_sp", i),  32'(sp_level),  32'(vecs[i].sp));
            check($sformatf("v%0d_isr", i), 32'(in_isr),    32'(vecs[i].isr));
            check($sformatf("v%0d_ack", i), 32'(irq_ack),   32'(vecs[i].ack));
            check($sformatf("v%0d_ovf", i), 32'(stack_ovf), 32'(vecs[i].ovf));
            check($sformatf("v%0d_unf", i), 32'(stack_unf), 32'(vecs[i].unf));
        end

        // Nine nested calls into a depth-8 stack, then nine returns.
        do_reset();
        mpc = 10'h0;
        mstack.delete();
        for (int c = 1; c <= 9; c++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 10'(32'h100 + (c - 1) * 32'h10), 4'h0, 1'b0, 1'b0);
            if (mstack.size() < 8) mstack.push_back(mpc + 10'd1);
            mpc = 10'(32'h100 + (c - 1) * 32'h10);
            tick();
            check($sformatf("call%0d_pc", c), 32'(pc), 32'(mpc));
        end
        check("call9_sp",  32'(sp_level),  32'd8);
        check("call9_ovf", 32'(stack_ovf), 32'd1);
        check("call9_unf", 32'(stack_unf), 32'd0);
        for (int r = 1; r <= 9; r++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h3FF, 4'h0, 1'b0, 1'b0);
            if (mstack.size() > 0) mpc = mstack.pop_back();
            else mpc = mpc + 10'd1;
            tick();
            check($sformatf("ret%0d_pc", r), 32'(pc), 32'(mpc));
            check($sformatf("ret%0d_sp", r), 32'(sp_level), 32'(mstack.size()));
        end
        check("ret9_unf", 32'(stack_unf), 32'd1);
        check("ret9_ovf", 32'(stack_ovf), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 4'h0, 1'b0, 1'b1);
        tick();
        check("clr_ovf", 32'(stack_ovf), 32'd0);
        check("clr_unf", 32'(stack_unf), 32'd0);
        check("clr_pc",  32'(pc),        32'(mpc + 10'd1));

        // Two calls then an interrupt, then reset between clock edges.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h040, 4'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h080, 4'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 4'b0100, 1'b1, 1'b0);
        tick();
        check("pre_rst_pc",  32'(pc),       32'h3C8);
        check("pre_rst_sp",  32'(sp_level), 32'd3);
        check("pre_rst_isr", 32'(in_isr),   32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 4'b0000, 1'b0, 1'b0);
        tick();
        check("pre_rst_unf", 32'(stack_unf), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 4'b0001, 1'b1, 1'b0);
        tick();
        check("pre_rst_isr2", 32'(in_isr), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_pc",  32'(pc),        32'h0);
        check("async_sp",  32'(sp_level),  32'h0);
        check("async_isr", 32'(in_isr),    32'h0);
        check("async_unf", 32'(stack_unf), 32'h0);
        check("async_ovf", 32'(stack_ovf), 32'h0);
        idle();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_pc", 32'(pc), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
